// File: rtl/imem_pkg.sv
// imem_pkg: shared constants and loader FSM state for the instruction-memory controller
package imem_pkg;
  localparam int IMEM_DEPTH = 128;
  localparam int IMEM_AW = 7;
  localparam logic [31:0] NOP_INST = 32'h00000013;
  typedef enum logic [1:0] {IDLE, LOAD, FILL, RESTART} imem_ld_state_t;
endpackage

// File: rtl/imem_bytes.sv
// imem_bytes: writable byte-array instruction memory, one byte write port, big-endian word read
module imem_bytes
  import imem_pkg::*;
#(
  parameter int DEPTH = IMEM_DEPTH,
  parameter int AW = IMEM_AW
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [7:0]    wdata,
  input  logic [31:0]   raddr,
  output logic [31:0]   rdata
);
  logic [7:0] mem [DEPTH];
  always_ff @(posedge clk)
    if (we) mem[waddr] <= wdata;
  // 33-bit byte address so a fetch near 2^32 cannot wrap back into the array
  for (genvar i = 0; i < 4; i++) begin : g_rd
    logic [32:0] a;
    assign a = {1'b0, raddr} + 33'(i);
    assign rdata[31-8*i -: 8] = a < 33'(DEPTH) ? mem[a[AW-1:0]] : 8'h00;
  end
endmodule

// File: rtl/imem_load_ctrl.sv
// imem_load_ctrl: sequences a byte-stream program load into instruction memory, zero-fills, restarts the CPU
module imem_load_ctrl
  import imem_pkg::*;
#(
  parameter int DEPTH = IMEM_DEPTH,
  parameter int AW = IMEM_AW
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          ld_valid,
  input  logic [7:0]    ld_data,
  input  logic          ld_last,
  output logic          ld_ready,
  input  logic [31:0]   cpu_addr,
  output logic [31:0]   cpu_inst,
  output logic          cpu_stall,
  output logic          cpu_restart,
  output logic          mem_we,
  output logic [AW-1:0] mem_waddr,
  output logic [7:0]    mem_wdata,
  output logic [31:0]   mem_raddr,
  input  logic [31:0]   mem_rdata,
  output logic [AW:0]   load_count,
  output logic          load_err
);
  imem_ld_state_t state;
  logic [AW-1:0] fptr;
  logic hs, full, done;
  assign hs = ld_valid & ld_ready;
  assign full = load_count[AW];
  assign done = full | load_count == (AW+1)'(DEPTH-1);
  assign mem_raddr = cpu_addr;
  assign cpu_inst = cpu_stall ? NOP_INST : mem_rdata;
  // reset gates the write strobe so an async reset takes effect before the next edge
  assign mem_we = ~reset & (state == FILL | hs & (state == IDLE | state == LOAD & ~full));
  assign mem_waddr = state == FILL ? fptr : state == LOAD ? load_count[AW-1:0] : '0;
  assign mem_wdata = mem_we & state != FILL ? ld_data : 8'h00;
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state <= IDLE;
      ld_ready <= 1'b1;
      cpu_stall <= 1'b0;
      cpu_restart <= 1'b0;
      load_count <= '0;
      load_err <= 1'b0;
      fptr <= '0;
    end else
      case (state)
        IDLE: if (hs) begin
          state <= ld_last ? FILL : LOAD;
          ld_ready <= ~ld_last;
          cpu_stall <= 1'b1;
          load_count <= (AW+1)'(1);
          load_err <= 1'b0;
          fptr <= AW'(1);
        end
        LOAD: if (hs) begin
          if (full) load_err <= 1'b1;
          else load_count <= load_count + (AW+1)'(1);
          fptr <= load_count[AW-1:0] + AW'(1);
          if (ld_last) begin
            ld_ready <= 1'b0;
            state <= done ? RESTART : FILL;
            cpu_restart <= done;
          end
        end
        FILL: begin
          fptr <= fptr + AW'(1);
          if (fptr == AW'(DEPTH-1)) begin
            state <= RESTART;
            cpu_restart <= 1'b1;
          end
        end
        default: begin
          state <= IDLE;
          cpu_restart <= 1'b0;
          cpu_stall <= 1'b0;
          ld_ready <= 1'b1;
        end
      endcase
endmodule
